// File: rtl/pim_pkg.sv
// Shared definitions for the PIM instruction dispatcher: instruction layout,
// class encodings, FSM state type and instruction builders.
package pim_pkg;

    localparam int INSTR_W   = 45;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int OP_W      = 2;
    localparam int CLASS_W   = 3;
    localparam int CLASS_MSB = 44;
    localparam int CLASS_LSB = 42;
    localparam int ALU_BIT   = 44;
    localparam int ALU_PAD_W = 12;

    localparam logic [CLASS_W-1:0] CLASS_READ  = 3'b000;
    localparam logic [CLASS_W-1:0] CLASS_WRITE = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [INSTR_W-1:0] make_mem(input logic [CLASS_W-1:0] cls,
                                                    input logic [ADDR_W-1:0]  addr,
                                                    input logic [DATA_W-1:0]  data);
        return {cls, addr, data};
    endfunction

    function automatic logic [INSTR_W-1:0] make_alu(input logic [OP_W-1:0]   op,
                                                    input logic [ADDR_W-1:0] src1,
                                                    input logic [ADDR_W-1:0] src2,
                                                    input logic [ADDR_W-1:0] dst);
        return {1'b1, op, src1, src2, dst, {ALU_PAD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/pim_instr_dispatcher_if.sv
// Host-side and control-unit-side signals of the dispatcher; the dispatcher
// connects through the slave modport, the driver of the block uses master.
interface pim_instr_dispatcher_if;
    import pim_pkg::*;

    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic [INSTR_W-1:0] instruction;
    logic               operation_enable;
    logic               cu_ready;
    logic               busy;
    logic               done;
    logic               timeout_err;

    modport slave (
        input  in_valid, in_instr, cu_ready,
        output in_ready, instruction, operation_enable, busy, done, timeout_err
    );

    modport master (
        output in_valid, in_instr, cu_ready,
        input  in_ready, instruction, operation_enable, busy, done, timeout_err
    );

endinterface

// File: rtl/pim_instr_fifo.sv
// Synchronous instruction queue of DEPTH entries with occupancy count; exposes
// both the head and the entry behind it so the dispatcher can chain issues.
module pim_instr_fifo
    import pim_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_data,
    input  logic               pop,
    output logic [INSTR_W-1:0] head,
    output logic [INSTR_W-1:0] next_head,
    output logic [CNT_W-1:0]   count
);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Guards keep the queue consistent even if a caller misbehaves.
    assign do_push = push && (count < CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/pim_instr_dispatcher.sv
// Queues host instructions and issues them one at a time to the PIM control
// unit. Optional WAIT timeout is built when PIM_DISPATCH_TIMEOUT_EN is defined.
module pim_instr_dispatcher
    import pim_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int EN_CYCLES      = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    pim_instr_dispatcher_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int EN_W  = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
    localparam logic [EN_W-1:0] EN_LAST = EN_W'(EN_CYCLES - 1);

    // Elaborates only for an illegal configuration; nothing inside drives logic.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || EN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_illegal
    end

    state_t             state;
    state_t             state_nx;
    logic [EN_W-1:0]    en_cnt;
    logic               cu_prev;
    logic               cu_rise;
    logic               timed_out;
    logic               push;
    logic               pop;
    logic               load_head;
    logic               load_next;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] head;
    logic [INSTR_W-1:0] next_head;
    logic [CNT_W-1:0]   count;

    assign bus.in_ready = (count < CNT_W'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;

    pim_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.in_instr),
        .pop       (pop),
        .head      (head),
        .next_head (next_head),
        .count     (count)
    );

    assign cu_rise = bus.cu_ready && !cu_prev;

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        load_head = 1'b0;
        load_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    state_nx  = ST_ISSUE;
                    load_head = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (en_cnt == EN_LAST) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cu_rise) begin
                    state_nx = ST_DONE;
                end else if (timed_out) begin
                    // Dropped instruction leaves exactly like a completed one, minus done.
                    pop = 1'b1;
                    if (count > CNT_W'(1)) begin
                        state_nx  = ST_ISSUE;
                        load_next = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                pop = 1'b1;
                if (count > CNT_W'(1)) begin
                    state_nx  = ST_ISSUE;
                    load_next = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            en_cnt  <= '0;
            cu_prev <= 1'b0;
            instr_q <= '0;
        end else begin
            state   <= state_nx;
            cu_prev <= bus.cu_ready;
            if (state == ST_ISSUE) begin
                en_cnt <= en_cnt + EN_W'(1);
            end else begin
                en_cnt <= '0;
            end
            // The head being popped is still in the queue, so chained issues take the next slot.
            if (load_head) begin
                instr_q <= head;
            end else if (load_next) begin
                instr_q <= next_head;
            end
        end
    end

`ifdef PIM_DISPATCH_TIMEOUT_EN
    localparam int WT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WT_W-1:0] wait_cnt;
    logic            timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + WT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (timed_out) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timed_out       = (state == ST_WAIT) && !cu_rise &&
                             (wait_cnt == WT_W'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_err = timeout_q;
`else
    assign timed_out       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.instruction      = instr_q;
    assign bus.operation_enable = (state == ST_ISSUE);
    assign bus.done             = (state == ST_DONE);
    assign bus.busy             = (state != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_pim_instr_dispatcher.sv
// Self-checking bench for pim_instr_dispatcher: table of single-instruction
// vectors plus hand-written multi-cycle sequences, with an issue-order scoreboard.
module tb_pim_instr_dispatcher;
    import pim_pkg::*;

    localparam int DEPTH     = 4;
    localparam int EN_CYCLES = 2;
`ifdef PIM_DISPATCH_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 8;
`else
    localparam int TIMEOUT_CYCLES = 64;
`endif

    typedef struct {
        logic [INSTR_W-1:0] instr;
        int                 cu_delay;
        int                 exp_en;
        int                 exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pim_instr_dispatcher_if bus();

    pim_instr_dispatcher #(
        .DEPTH          (DEPTH),
        .EN_CYCLES      (EN_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic en_prev = 1'b0;
    logic [INSTR_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted pushes, compare each new issue against the oldest.
    always @(negedge clk) begin
        if (rst && bus.in_valid && bus.in_ready) begin
            exp_q.push_back(bus.in_instr);
        end
        if (bus.done) begin
            done_cnt++;
        end
        if (bus.operation_enable && !en_prev) begin
            check("issue_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("issue_order", 64'(bus.instruction), 64'(exp_q.pop_front()));
            end
        end
        en_prev = bus.operation_enable;
    end

    task automatic wait_wait_state(input string name);
        int n = 0;
        while (!bus.operation_enable && n < 20) begin tick(); n++; end
        while (bus.operation_enable && n < 20) begin tick(); n++; end
        check(name, 64'(n < 20), 1);
    endtask

    task automatic pulse_done(input string name);
        int n = 0;
        bus.cu_ready = 1'b1;
        tick();
        bus.cu_ready = 1'b0;
        while (!bus.done && n < 8) begin tick(); n++; end
        check(name, 64'(bus.done), 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int d0;
        int lat;
        int en_len;
        d0 = done_cnt;
        bus.in_valid = 1'b1;
        bus.in_instr = v.instr;
        tick();
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        lat = 0;
        while (!bus.operation_enable && lat < 10) begin tick(); lat++; end
        check($sformatf("vec%0d_issue_latency", idx), 64'(lat), 1);
        en_len = 0;
        while (bus.operation_enable && en_len < 10) begin
            check($sformatf("vec%0d_instr_hold", idx), 64'(bus.instruction), 64'(v.instr));
            tick();
            en_len++;
        end
        check($sformatf("vec%0d_enable_len", idx), 64'(en_len), 64'(v.exp_en));
        repeat (v.cu_delay) tick();
        check($sformatf("vec%0d_no_early_done", idx), 64'(done_cnt - d0), 0);
        pulse_done($sformatf("vec%0d_done", idx));
        tick();
        check($sformatf("vec%0d_idle", idx), 64'(bus.busy), 0);
        check($sformatf("vec%0d_done_pulses", idx), 64'(done_cnt - d0), 64'(v.exp_done));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[4];
        logic [INSTR_W-1:0] fill[5];
        logic [INSTR_W-1:0] ins;
        int d0;
        int seen;

        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.cu_ready = 1'b0;

        vecs[0] = '{make_mem(CLASS_WRITE, 10'h38A, 32'h12345678), 0, EN_CYCLES, 1};
        vecs[1] = '{make_mem(CLASS_READ, 10'h000, 32'h0), 2, EN_CYCLES, 1};
        vecs[2] = '{make_alu(2'b11, 10'h3FF, 10'h155, 10'h2AA), 3, EN_CYCLES, 1};
        vecs[3] = '{make_mem(CLASS_WRITE, 10'h3FF, 32'hFFFFFFFF), 1, EN_CYCLES, 1};

        // Reset values
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 1);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_op_en", 64'(bus.operation_enable), 0);
        check("rst_done", 64'(bus.done), 0);
        check("rst_instruction", 64'(bus.instruction), 0);
        check("rst_timeout_err", 64'(bus.timeout_err), 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-to-back read then ALU
        d0 = done_cnt;
        bus.in_valid = 1'b1;
        bus.in_instr = make_mem(CLASS_READ, 10'h38A, 32'h0);
        tick();
        bus.in_instr = make_alu(2'b01, 10'h000, 10'h38A, 10'h045);
        tick();
        bus.in_valid = 1'b0;
        wait_wait_state("b2b_wait1");
        pulse_done("b2b_done1");
        tick();
        check("b2b_reissue", 64'(bus.operation_enable), 1);
        wait_wait_state("b2b_wait2");
        pulse_done("b2b_done2");
        tick();
        check("b2b_idle", 64'(bus.busy), 0);
        check("b2b_done_pulses", 64'(done_cnt - d0), 2);

        // Fill to DEPTH with cu_ready low; fifth push is refused until a pop
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            fill[i] = make_mem(CLASS_WRITE, 10'(i * 37 + 5), 32'hA5A50000 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = fill[i];
            check($sformatf("fill%0d_ready", i), 64'(bus.in_ready), 1);
            tick();
        end
        bus.in_instr = fill[4];
        check("full_ready_low", 64'(bus.in_ready), 0);
        tick();
        check("full_ready_still_low", 64'(bus.in_ready), 0);
        pulse_done("full_done_first");
        check("full_pop_cycle_refused", 64'(bus.in_ready), 0);
        tick();
        check("full_ready_after_pop", 64'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        check("full_again", 64'(bus.in_ready), 0);
        for (int i = 0; i < 4; i++) begin
            wait_wait_state($sformatf("drain%0d_wait", i));
            pulse_done($sformatf("drain%0d_done", i));
        end
        tick();
        check("drain_idle", 64'(bus.busy), 0);
        check("drain_done_pulses", 64'(done_cnt - d0), 5);

        // Level-high cu_ready does not complete
        d0 = done_cnt;
        bus.cu_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = make_alu(2'b10, 10'h111, 10'h222, 10'h333);
        tick();
        bus.in_valid = 1'b0;
        repeat (6) tick();
        check("level_no_done", 64'(done_cnt - d0), 0);
        check("level_op_en_low", 64'(bus.operation_enable), 0);
        check("level_busy", 64'(bus.busy), 1);
        bus.cu_ready = 1'b0;
        tick();
        pulse_done("level_done_after_edge");
        tick();
        check("level_idle", 64'(bus.busy), 0);
        check("level_done_pulses", 64'(done_cnt - d0), 1);

`ifdef PIM_DISPATCH_TIMEOUT_EN
        // Timeout drops the stuck instruction and issues the next
        d0 = done_cnt;
        bus.in_valid = 1'b1;
        bus.in_instr = make_mem(CLASS_READ, 10'h0F0, 32'h0);
        tick();
        bus.in_instr = make_mem(CLASS_WRITE, 10'h00F, 32'hDEADBEEF);
        tick();
        bus.in_valid = 1'b0;
        wait_wait_state("to_wait");
        repeat (7) tick();
        check("to_not_yet", 64'(bus.timeout_err), 0);
        tick();
        check("to_set", 64'(bus.timeout_err), 1);
        check("to_next_issued", 64'(bus.operation_enable), 1);
        check("to_no_done", 64'(done_cnt - d0), 0);
        wait_wait_state("to_wait2");
        pulse_done("to_done2");
        tick();
        check("to_sticky", 64'(bus.timeout_err), 1);
        check("to_idle", 64'(bus.busy), 0);
`else
        // Without the timeout the block waits indefinitely
        d0 = done_cnt;
        bus.in_valid = 1'b1;
        bus.in_instr = make_mem(CLASS_READ, 10'h0F0, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        wait_wait_state("nto_wait");
        repeat (80) tick();
        check("nto_no_done", 64'(done_cnt - d0), 0);
        check("nto_busy", 64'(bus.busy), 1);
        check("nto_err_zero", 64'(bus.timeout_err), 0);
        pulse_done("nto_done");
        tick();
        check("nto_idle", 64'(bus.busy), 0);
`endif

        // Asynchronous reset during WAIT with two entries queued
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ins = make_mem(CLASS_WRITE, 10'(100 + i), 32'h0BAD0000 + 32'(i));
            bus.in_instr = ins;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        wait_wait_state("rw_wait");
        check("rw_busy", 64'(bus.busy), 1);
        d0 = done_cnt;
        #2;
        rst = 1'b0;
        #1;
        check("rw_op_en", 64'(bus.operation_enable), 0);
        check("rw_done", 64'(bus.done), 0);
        check("rw_busy_cleared", 64'(bus.busy), 0);
        check("rw_in_ready", 64'(bus.in_ready), 1);
        check("rw_instruction", 64'(bus.instruction), 0);
        check("rw_timeout_err", 64'(bus.timeout_err), 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (bus.operation_enable || bus.busy) seen++;
        end
        check("rw_nothing_issued", 64'(seen), 0);
        check("rw_no_done", 64'(done_cnt - d0), 0);

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
